fifo_word_packer: RTL and testbench



---
 rtl/fifo_packer_pkg.sv | 17 +
 rtl/packer_out_reg.sv | 31 +++
 rtl/fifo_word_packer.sv | 108 ++++++++++
 tb/tb_fifo_word_packer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_packer_pkg.sv
// Shared types and constants for the FIFO byte-to-word packer.
package fifo_packer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StFinish
  } state_e;

  localparam int unsigned DefaultBpwLog2      = 2;
  localparam int unsigned DefaultBytesPerWord = 1 << DefaultBpwLog2;

  function automatic int unsigned bpw_log2(input int unsigned bpw);
    return $clog2(bpw);
  endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Single-entry valid/ready output register holding a packed word and its last flag.
module packer_out_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             load_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  output logic             out_last
);

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_word  <= load_word;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs bytes popped from a one-cycle-latency SRAM FIFO into words for the PE-array loader.
module fifo_word_packer
  import fifo_packer_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned BYTES_PER_WORD = DefaultBytesPerWord,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               arst_n_in,
  input  logic                               start,
  input  logic [CNT_WIDTH-1:0]               cfg_num_words,
  input  logic [BYTE_WIDTH-1:0]              in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] out_word,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned Log2Bpw   = bpw_log2(BYTES_PER_WORD);
  localparam int unsigned WordWidth = BYTE_WIDTH * BYTES_PER_WORD;
  localparam int unsigned PopWidth  = CNT_WIDTH + Log2Bpw;
  localparam int unsigned FillWidth = Log2Bpw + 1;
  localparam logic [FillWidth-1:0] FillFull = FillWidth'(BYTES_PER_WORD);

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   words_left_q;
  logic [PopWidth-1:0]    bytes_to_pop_q;
  logic [FillWidth-1:0]   fill_q;
  logic                   pending_q;
  logic [WordWidth-1:0]   asm_q;

  logic                   transfer;
  logic [FillWidth-1:0]   fill_eff;

  assign transfer = (state_q == StPack) && (fill_q == FillFull) && (!out_valid || out_ready);
  // A transferring assembly register is already free, so the next word's pops may start now.
  assign fill_eff = transfer ? '0 : fill_q;
  assign in_ready = (state_q == StPack) && in_valid && (bytes_to_pop_q != '0) &&
                    ((fill_eff + FillWidth'(pending_q)) < FillFull);

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFinish);

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_q        <= StIdle;
      words_left_q   <= '0;
      bytes_to_pop_q <= '0;
      fill_q         <= '0;
      pending_q      <= 1'b0;
      asm_q          <= '0;
    end else begin
      pending_q <= in_ready;
      if (in_ready) begin
        bytes_to_pop_q <= bytes_to_pop_q - PopWidth'(1);
      end
      // SRAM data lands the cycle after the pop, independent of in_valid now.
      if (pending_q) begin
        asm_q[int'(fill_q[Log2Bpw-1:0]) * BYTE_WIDTH +: BYTE_WIDTH] <= in_data;
        fill_q <= fill_q + FillWidth'(1);
      end
      if (transfer) begin
        fill_q       <= '0;
        words_left_q <= words_left_q - CNT_WIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_num_words != '0) begin
              state_q        <= StPack;
              words_left_q   <= cfg_num_words;
              bytes_to_pop_q <= {cfg_num_words, {Log2Bpw{1'b0}}};
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StPack: begin
          if (out_valid && out_ready && out_last) begin
            state_q <= StFinish;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  packer_out_reg #(
    .WIDTH (WordWidth)
  ) u_out_reg (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .load      (transfer),
    .load_word (asm_q),
    .load_last (words_left_q == CNT_WIDTH'(1)),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: SRAM FIFO model, word scoreboard and per-scenario tasks.
module tb_fifo_word_packer;

  localparam int unsigned BW  = 8;
  localparam int unsigned BPW = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned WW  = BW * BPW;

  typedef struct packed {
    logic [WW-1:0] word;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_num_words = '0;
  logic [BW-1:0] in_data = '0;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] out_word;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] mem [256];
  logic [7:0]    wr_ptr = '0;
  logic [7:0]    rd_ptr = '0;
  int            pops = 0;
  exp_t          sb[$];
  int            words_out = 0;
  int            valid_cycles = 0;
  int            done_cnt = 0;
  logic          hold_prev = 1'b0;
  logic [WW-1:0] prev_word = '0;
  logic          prev_last = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .BYTE_WIDTH     (BW),
    .BYTES_PER_WORD (BPW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .start         (start),
    .cfg_num_words (cfg_num_words),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  assign in_valid = (wr_ptr != rd_ptr);

  // SRAM-backed FIFO: qout shows the popped entry one cycle after the pop.
  always @(posedge clk) begin
    if (in_ready) begin
      checks++;
      if (!in_valid) begin
        errors++;
        $display("FAIL pop_when_empty: in_ready=1 with in_valid=0 (required in_ready=0)");
      end
      in_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 8'd1;
      pops    <= pops + 1;
    end
  end

  // Output monitor: scoreboard compare on each handshake plus hold-stability check.
  always @(negedge clk) begin
    if (arst_n_in) begin
      if (hold_prev && out_valid) begin
        checks++;
        if (out_word !== prev_word || out_last !== prev_last) begin
          errors++;
          $display("FAIL out_hold: word=%h last=%b, required word=%h last=%b",
                   out_word, out_last, prev_word, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        exp_t e;
        checks++;
        words_out++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: word=%h last=%b, required no word", out_word, out_last);
        end else begin
          e = sb.pop_front();
          if (out_word !== e.word || out_last !== e.last) begin
            errors++;
            $display("FAIL word: word=%h last=%b, required word=%h last=%b",
                     out_word, out_last, e.word, e.last);
          end
        end
      end
      if (out_valid) valid_cycles++;
      if (done) done_cnt++;
      hold_prev = out_valid && !out_ready;
      prev_word = out_word;
      prev_last = out_last;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fifo(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 8'(base + i);
      wr_ptr      = wr_ptr + 8'd1;
    end
  endtask

  task automatic push_exp(input int nwords, input int base);
    for (int i = 0; i < nwords; i++) begin
      exp_t e;
      e.word = '0;
      for (int j = 0; j < int'(BPW); j++) e.word[j*BW +: BW] = 8'(base + i*int'(BPW) + j);
      e.last = (i == nwords - 1);
      sb.push_back(e);
    end
  endtask

  task automatic start_job(input int n);
    cfg_num_words = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout: done=0 after %0d cycles, required done=1", name, budget);
    end
    tick();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    start = 1'b1;
    cfg_num_words = CW'(3);
    repeat (3) tick();
    checks++;
    if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_word !== '0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_last=%b busy=%b done=%b word=%h, required all 0",
               in_ready, out_valid, out_last, busy, done, out_word);
    end
    start = 1'b0;
    arst_n_in = 1'b1;
    repeat (2) tick();
    check_int("idle_busy", int'(busy), 0);
    check_int("idle_done", int'(done), 0);
  endtask

  task automatic test_zero_job();
    int p0, v0, d0;
    p0 = pops; v0 = valid_cycles; d0 = done_cnt;
    load_fifo(4, 'hF0);
    start_job(0);
    check_int("zero_done_pulse", int'(done), 1);
    check_int("zero_busy_finish", int'(busy), 1);
    tick();
    check_int("zero_done_cleared", int'(done), 0);
    check_int("zero_busy_cleared", int'(busy), 0);
    repeat (3) tick();
    check_int("zero_no_pops", pops - p0, 0);
    check_int("zero_no_valid", valid_cycles - v0, 0);
    check_int("zero_done_count", done_cnt - d0, 1);
    wr_ptr = rd_ptr;
  endtask

  task automatic test_two_words();
    int p0, w0, d0, k;
    p0 = pops; w0 = words_out; d0 = done_cnt;
    out_ready = 1'b1;
    load_fifo(8, 'h11);
    push_exp(2, 'h11);
    start_job(2);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    // One cycle from the start edge to the first pop, then BPW+1 to the first word.
    check_int("first_word_latency", k, int'(BPW) + 2);
    wait_done(40, "two_words");
    check_int("two_words_pops", pops - p0, 8);
    check_int("two_words_count", words_out - w0, 2);
    check_int("two_words_done", done_cnt - d0, 1);
    check_int("two_words_sb_empty", sb.size(), 0);
  endtask

  task automatic test_backpressure();
    int p0, w0, d0;
    p0 = pops; w0 = words_out; d0 = done_cnt;
    out_ready = 1'b0;
    load_fifo(12, 'h21);
    push_exp(3, 'h21);
    start_job(3);
    repeat (20) tick();
    check_int("bp_pops_stalled", pops - p0, 8);
    check_int("bp_in_valid", int'(in_valid), 1);
    check_int("bp_in_ready", int'(in_ready), 0);
    check_int("bp_out_valid", int'(out_valid), 1);
    check_int("bp_no_done", done_cnt - d0, 0);
    out_ready = 1'b1;
    wait_done(60, "bp");
    check_int("bp_pops_total", pops - p0, 12);
    check_int("bp_words", words_out - w0, 3);
    check_int("bp_sb_empty", sb.size(), 0);
  endtask

  task automatic test_fifo_empty();
    int p0, w0;
    p0 = pops; w0 = words_out;
    out_ready = 1'b1;
    load_fifo(2, 'h31);
    push_exp(1, 'h31);
    start_job(1);
    repeat (10) tick();
    check_int("empty_pops_held", pops - p0, 2);
    check_int("empty_no_word", int'(out_valid), 0);
    check_int("empty_busy", int'(busy), 1);
    load_fifo(2, 'h33);
    wait_done(30, "empty");
    check_int("empty_pops_total", pops - p0, 4);
    check_int("empty_words", words_out - w0, 1);
  endtask

  task automatic test_one_word_leftover();
    int p0;
    p0 = pops;
    out_ready = 1'b1;
    load_fifo(12, 'h41);
    push_exp(1, 'h41);
    start_job(1);
    wait_done(30, "leftover");
    repeat (3) tick();
    check_int("leftover_pops", pops - p0, 4);
    check_int("leftover_level", int'(8'(wr_ptr - rd_ptr)), 8);
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset_mid_job();
    int d0, w0;
    out_ready = 1'b1;
    load_fifo(8, 'h51);
    start_job(2);
    repeat (2) tick();
    d0 = done_cnt;
    arst_n_in = 1'b0;
    repeat (2) tick();
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_out_valid", int'(out_valid), 0);
    arst_n_in = 1'b1;
    wr_ptr = rd_ptr;
    repeat (3) tick();
    check_int("abort_no_done", done_cnt - d0, 0);
    w0 = words_out;
    load_fifo(4, 'h61);
    push_exp(1, 'h61);
    start_job(1);
    wait_done(30, "restart");
    check_int("restart_words", words_out - w0, 1);
    check_int("restart_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_job();
    test_two_words();
    test_backpressure();
    test_fifo_empty();
    test_one_word_leftover();
    test_reset_mid_job();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
